// File: rtl/id_debug_stage.sv
// Decode stage: ID/EX pipeline register, load-use hazard detection and an optional
// multi-breakpoint halt/step debug controller (built only when ID_BREAKPOINT_EN is defined).
module id_debug_stage #(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 4,
    parameter int CTRL_W = 24,
    parameter int BPI_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_id_instruction,
    input  logic [XLEN-1:0]   if_id_pc_next,
    input  logic              if_id_valid,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush_id,
    input  logic              bp_wr_en,
    input  logic [BPI_W-1:0]  bp_wr_idx,
    input  logic [XLEN-1:0]   bp_wr_addr,
    input  logic              bp_wr_arm,
    input  logic              continue_sig,
    input  logic              step_sig,
    output logic              id_ex_valid,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic [4:0]        id_ex_rs,
    output logic [4:0]        id_ex_rt,
    output logic [4:0]        id_ex_rd,
    output logic [4:0]        id_ex_shamt,
    output logic [XLEN-1:0]   id_ex_imm_sign_extended,
    output logic [XLEN-1:0]   id_ex_pc_next,
    output logic              stall,
    output logic              stall_breakpoint,
    output logic [BPI_W-1:0]  bp_hit_idx,
    output logic [1:0]        dbg_state
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc_next;
    } id_ex_t;

    id_ex_t dec, id_ex_d, id_ex_q;
    logic   dbg_block;
    logic   load_en;

    always_comb begin
        dec.valid   = if_id_valid;
        dec.ctrl    = ctrl_in;
        dec.rs      = if_id_instruction[25:21];
        dec.rt      = if_id_instruction[20:16];
        dec.rd      = if_id_instruction[15:11];
        dec.shamt   = if_id_instruction[10:6];
        dec.imm     = {{(XLEN-16){if_id_instruction[15]}}, if_id_instruction[15:0]};
        dec.pc_next = if_id_pc_next;
    end

    // r0 never carries a real dependency, so a load targeting it cannot stall
    assign stall = id_ex_q.valid & id_ex_q.ctrl[1] & (id_ex_q.rt != 5'd0) &
                   ((id_ex_q.rt == dec.rs) | (id_ex_q.rt == dec.rt));

    assign load_en = ~flush_id & ~stall & ~dbg_block;

    always_comb begin
        id_ex_d = '0;
        if (load_en) id_ex_d = dec;
    end

    always_ff @(posedge clk) begin
        if (rst) id_ex_q <= '0;
        else     id_ex_q <= id_ex_d;
    end

    assign id_ex_valid             = id_ex_q.valid;
    assign id_ex_ctrl              = id_ex_q.ctrl;
    assign id_ex_rs                = id_ex_q.rs;
    assign id_ex_rt                = id_ex_q.rt;
    assign id_ex_rd                = id_ex_q.rd;
    assign id_ex_shamt             = id_ex_q.shamt;
    assign id_ex_imm_sign_extended = id_ex_q.imm;
    assign id_ex_pc_next           = id_ex_q.pc_next;

`ifdef ID_BREAKPOINT_EN
    localparam logic [1:0] RUN  = 2'b00;
    localparam logic [1:0] HALT = 2'b01;
    localparam logic [1:0] STEP = 2'b10;

    logic [XLEN-1:0]  bp_addr_q [NUM_BP];
    logic [XLEN-1:0]  bp_addr_d [NUM_BP];
    logic [NUM_BP-1:0] bp_arm_q, bp_arm_d, hit;
    logic [BPI_W-1:0] hit_lo, bp_hit_idx_q, bp_hit_idx_d;
    logic [1:0]       state_q, state_d;
    logic             skip_q, skip_d;
    logic [XLEN-1:0]  pc_cur;
    logic             match, issue;

    assign pc_cur = if_id_pc_next - XLEN'(4);

    always_comb begin
        bp_addr_d = bp_addr_q;
        bp_arm_d  = bp_arm_q;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_wr_en && bp_wr_idx == BPI_W'(i)) begin
                bp_addr_d[i] = bp_wr_addr;
                bp_arm_d[i]  = bp_wr_arm;
            end
        end
    end

    always_comb begin
        hit    = '0;
        hit_lo = '0;
        for (int i = 0; i < NUM_BP; i++) hit[i] = bp_arm_q[i] && (bp_addr_q[i] == pc_cur);
        for (int i = NUM_BP - 1; i >= 0; i--) if (hit[i]) hit_lo = BPI_W'(i);
    end

    // skip lets the instruction just released from HALT pass its own breakpoint
    assign match = if_id_valid & ~flush_id & ~skip_q & (|hit);
    assign issue = load_en & if_id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            skip_q       <= 1'b0;
            bp_hit_idx_q <= '0;
            bp_arm_q     <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            bp_hit_idx_q <= bp_hit_idx_d;
            bp_arm_q     <= bp_arm_d;
            bp_addr_q    <= bp_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        bp_hit_idx_d = bp_hit_idx_q;
        case (state_q)
            RUN: if (match) begin
                state_d      = HALT;
                bp_hit_idx_d = hit_lo;
            end
            HALT: if (continue_sig) begin
                state_d = RUN;
                skip_d  = 1'b1;
            end else if (step_sig) begin
                state_d = STEP;
                skip_d  = 1'b1;
            end
            STEP: if (issue) state_d = HALT;
            default: state_d = RUN;
        endcase
        if (flush_id || issue) skip_d = 1'b0;
    end

    always_comb begin
        dbg_block = ((state_q == RUN) && match) || (state_q == HALT) ||
                    ((state_q == STEP) && !if_id_valid);
        stall_breakpoint = dbg_block & ~flush_id;
        dbg_state        = state_q;
        bp_hit_idx       = bp_hit_idx_q;
    end

    logic unused_bits;
    assign unused_bits = ^if_id_instruction[31:26];
`else
    assign dbg_block        = 1'b0;
    assign stall_breakpoint = 1'b0;
    assign bp_hit_idx       = '0;
    assign dbg_state        = 2'b00;

    logic unused_bits;
    assign unused_bits = ^{if_id_instruction[31:26], bp_wr_en, bp_wr_idx, bp_wr_addr,
                           bp_wr_arm, continue_sig, step_sig};
`endif

endmodule

// File: tb/tb_id_debug_stage.sv
// Scoreboard bench for id_debug_stage: stimulus queues expected ID/EX contents, the
// negedge monitor pops them whenever id_ex_valid is seen and checks combinational outputs.
module tb_id_debug_stage;

    localparam int XLEN = 32, NUM_BP = 3, CTRL_W = 24, BPI_W = 2;
    localparam logic [23:0] CT_LD  = 24'h000003;
    localparam logic [23:0] CT_ALU = 24'hC3C301;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       if_id_instruction;
    logic [XLEN-1:0]   if_id_pc_next;
    logic              if_id_valid;
    logic [CTRL_W-1:0] ctrl_in;
    logic              flush_id;
    logic              bp_wr_en;
    logic [BPI_W-1:0]  bp_wr_idx;
    logic [XLEN-1:0]   bp_wr_addr;
    logic              bp_wr_arm;
    logic              continue_sig;
    logic              step_sig;
    logic              id_ex_valid;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic [4:0]        id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
    logic [XLEN-1:0]   id_ex_imm_sign_extended;
    logic [XLEN-1:0]   id_ex_pc_next;
    logic              stall;
    logic              stall_breakpoint;
    logic [BPI_W-1:0]  bp_hit_idx;
    logic [1:0]        dbg_state;

    id_debug_stage #(.XLEN(XLEN), .NUM_BP(NUM_BP), .CTRL_W(CTRL_W), .BPI_W(BPI_W)) dut (
        .clk(clk), .rst(rst),
        .if_id_instruction(if_id_instruction), .if_id_pc_next(if_id_pc_next),
        .if_id_valid(if_id_valid), .ctrl_in(ctrl_in), .flush_id(flush_id),
        .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr),
        .bp_wr_arm(bp_wr_arm), .continue_sig(continue_sig), .step_sig(step_sig),
        .id_ex_valid(id_ex_valid), .id_ex_ctrl(id_ex_ctrl), .id_ex_rs(id_ex_rs),
        .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_shamt(id_ex_shamt),
        .id_ex_imm_sign_extended(id_ex_imm_sign_extended), .id_ex_pc_next(id_ex_pc_next),
        .stall(stall), .stall_breakpoint(stall_breakpoint),
        .bp_hit_idx(bp_hit_idx), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [23:0] ctrl;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] imm;
        logic [31:0] pcn;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] imm;
    } ins_t;

    // hand-encoded instructions with their expected decoded fields
    function automatic ins_t tbl(input int k);
        case (k)
            0: tbl = {32'h8FA8FFFC, 5'd29, 5'd8, 5'd31, 5'd31, 32'hFFFFFFFC}; // lw $t0,-4($sp)
            1: tbl = {32'h01095820, 5'd8,  5'd9, 5'd11, 5'd0,  32'h00005820}; // add $t3,$t0,$t1
            2: tbl = {32'h8FA00000, 5'd29, 5'd0, 5'd0,  5'd0,  32'h00000000}; // lw $zero,0($sp)
            3: tbl = {32'h00005020, 5'd0,  5'd0, 5'd10, 5'd0,  32'h00005020}; // add $t2,$0,$0
            4: tbl = {32'h00095140, 5'd0,  5'd9, 5'd10, 5'd5,  32'h00005140}; // sll $t2,$t1,5
            5: tbl = {32'h8FA9FFF0, 5'd29, 5'd9, 5'd31, 5'd31, 32'hFFFFFFF0}; // lw $t1,-16($sp)
            6: tbl = {32'h01095020, 5'd8,  5'd9, 5'd10, 5'd0,  32'h00005020}; // add $t2,$t0,$t1
            default: tbl = '0;                                               // nop
        endcase
    endfunction

    exp_t sb[$];
    int   n_vec = 0, n_err = 0, cyc = 0;
    bit   chk_comb = 0, chk_rst = 0, chk_hit = 0, done = 0;
    bit   e_stall, e_sbp;
    logic [1:0] e_state;
    logic [BPI_W-1:0] e_hit;

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t got, want;
        cyc++;
        got = {id_ex_valid, id_ex_ctrl, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt,
               id_ex_imm_sign_extended, id_ex_pc_next};
        if (chk_comb) begin
            cmp("stall", 128'(stall), 128'(e_stall));
            cmp("stall_breakpoint", 128'(stall_breakpoint), 128'(e_sbp));
            cmp("dbg_state", 128'(dbg_state), 128'(e_state));
        end
        if (chk_rst) begin
            cmp("reset_id_ex", 128'(got), 128'(0));
            cmp("reset_dbg_state", 128'(dbg_state), 128'(0));
            cmp("reset_bp_hit_idx", 128'(bp_hit_idx), 128'(0));
        end
        if (chk_hit) cmp("bp_hit_idx", 128'(bp_hit_idx), 128'(e_hit));
        if (id_ex_valid === 1'b1) begin
            if (sb.size() == 0) cmp("unexpected_issue", 128'(got), 128'(0));
            else begin
                want = sb.pop_front();
                cmp("id_ex", 128'(got), 128'(want));
            end
        end
        if (done || cyc > 5000) begin
            cmp("timeout", 128'(cyc > 5000), 128'(0));
            cmp("scoreboard_drained", 128'(sb.size()), 128'(0));
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // called at posedge+1; holds inputs for one full cycle
    task automatic apply(input int k, input logic [31:0] pcn, input logic [23:0] ct,
                         input bit v, input bit fl, input bit co, input bit st,
                         input bit es, input bit esb, input logic [1:0] est, input bit eiss);
        ins_t t;
        t = tbl(k);
        if_id_instruction = t.instr;
        if_id_pc_next     = pcn;
        ctrl_in           = ct;
        if_id_valid       = v;
        flush_id          = fl;
        continue_sig      = co;
        step_sig          = st;
        e_stall = es; e_sbp = esb; e_state = est;
        chk_comb = 1;
        if (eiss) sb.push_back({1'b1, ct, t.rs, t.rt, t.rd, t.shamt, t.imm, pcn});
        @(posedge clk); #1;
        bp_wr_en = 0; chk_hit = 0;
    endtask

    task automatic bpw(input int idx, input logic [31:0] addr, input bit arm,
                       input logic [1:0] est);
        bp_wr_en = 1; bp_wr_idx = BPI_W'(idx); bp_wr_addr = addr; bp_wr_arm = arm;
        apply(7, 32'h0, 24'h0, 0, 0, 0, 0, 0, 0, est, 0);
    endtask

    task automatic do_reset();
        chk_comb = 0;
        rst = 1;
        @(posedge clk); #1;
        chk_rst = 1;
        @(posedge clk); #1;
        chk_rst = 0;
        rst = 0;
    endtask

    initial begin
        if_id_instruction = 0; if_id_pc_next = 0; if_id_valid = 0; ctrl_in = 0;
        flush_id = 0; bp_wr_en = 0; bp_wr_idx = 0; bp_wr_addr = 0; bp_wr_arm = 0;
        continue_sig = 0; step_sig = 0;
        @(posedge clk); #1;
        do_reset();

        // load-use hazards: rs dependency, r0 target, rt dependency, flush
        apply(0, 32'h10, CT_LD,  1, 0, 0, 0, 0, 0, 2'b00, 1);
        apply(1, 32'h14, CT_ALU, 1, 0, 0, 0, 1, 0, 2'b00, 0);
        apply(1, 32'h14, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        apply(2, 32'h18, CT_LD,  1, 0, 0, 0, 0, 0, 2'b00, 1);
        apply(3, 32'h1C, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        apply(4, 32'h20, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        apply(5, 32'h24, CT_LD,  1, 0, 0, 0, 0, 0, 2'b00, 1);
        apply(4, 32'h28, CT_ALU, 1, 0, 0, 0, 1, 0, 2'b00, 0);
        apply(4, 32'h28, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        apply(6, 32'h2C, CT_ALU, 1, 1, 0, 0, 0, 0, 2'b00, 0);
        apply(7, 32'h0,  24'h0,  0, 0, 0, 0, 0, 0, 2'b00, 0);

`ifdef ID_BREAKPOINT_EN
        bpw(2, 32'h30, 1, 2'b00);
        bpw(1, 32'h40, 1, 2'b00);
        // halt at 0x30, then continue
        apply(4, 32'h34, CT_ALU, 1, 0, 0, 0, 0, 1, 2'b00, 0);
        chk_hit = 1; e_hit = 2;
        apply(4, 32'h34, CT_ALU, 1, 0, 0, 0, 0, 1, 2'b01, 0);
        apply(4, 32'h34, CT_ALU, 1, 0, 1, 0, 0, 1, 2'b01, 0);
        apply(4, 32'h34, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        // slot 0 also at 0x30, written alongside a valid instruction
        bp_wr_en = 1; bp_wr_idx = 0; bp_wr_addr = 32'h30; bp_wr_arm = 1;
        apply(6, 32'h38, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        // second pass halts again, lowest slot reported; then single-step
        apply(4, 32'h34, CT_ALU, 1, 0, 0, 0, 0, 1, 2'b00, 0);
        chk_hit = 1; e_hit = 0;
        apply(4, 32'h34, CT_ALU, 1, 0, 0, 0, 0, 1, 2'b01, 0);
        apply(4, 32'h34, CT_ALU, 1, 0, 0, 1, 0, 1, 2'b01, 0);
        apply(4, 32'h34, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b10, 1);
        apply(6, 32'h38, CT_ALU, 1, 0, 0, 0, 0, 1, 2'b01, 0);
        // step waits across an empty IF/ID
        apply(6, 32'h38, CT_ALU, 1, 0, 0, 1, 0, 1, 2'b01, 0);
        apply(7, 32'h0,  24'h0,  0, 0, 0, 0, 0, 1, 2'b10, 0);
        apply(6, 32'h38, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b10, 1);
        apply(2, 32'h3C, CT_LD,  1, 0, 0, 0, 0, 1, 2'b01, 0);
        // step and continue together: continue wins
        apply(2, 32'h3C, CT_LD,  1, 0, 1, 1, 0, 1, 2'b01, 0);
        apply(2, 32'h3C, CT_LD,  1, 0, 0, 0, 0, 0, 2'b00, 1);
        // flush suppresses the breakpoint at 0x40
        apply(3, 32'h44, CT_ALU, 1, 1, 0, 0, 0, 0, 2'b00, 0);
        apply(3, 32'h44, CT_ALU, 1, 0, 0, 0, 0, 1, 2'b00, 0);
        chk_hit = 1; e_hit = 1;
        apply(3, 32'h44, CT_ALU, 1, 0, 0, 0, 0, 1, 2'b01, 0);
        // reset while halted clears state and slots
        do_reset();
        apply(3, 32'h44, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        bpw(3, 32'h50, 1, 2'b00);
        apply(6, 32'h54, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        bp_wr_en = 1; bp_wr_idx = 1; bp_wr_addr = 32'h70; bp_wr_arm = 1;
        apply(4, 32'h74, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
`else
        bpw(2, 32'h30, 1, 2'b00);
        apply(4, 32'h34, CT_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        chk_hit = 1; e_hit = 0;
        apply(4, 32'h34, CT_ALU, 1, 0, 1, 1, 0, 0, 2'b00, 1);
`endif
        apply(7, 32'h0, 24'h0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        done = 1;
    end

endmodule

// File: doc/id_debug_stage.md
# id_debug_stage

Parametrised instruction-decode stage with integrated debug control: it registers the decoded instruction into the ID/EX pipeline register, detects load-use hazards, and hosts a programmable multi-breakpoint halt/step controller. It sits between the IF/ID register and the EX stage. The control decoder stays external and supplies a packed control bundle. Compared with the single-breakpoint decode stage, it adds:
- runtime-programmable breakpoints;
- single-step;
- a valid bit in the pipeline;
- r0-aware hazard detection.

## Interface
Parameters:
- XLEN, 32, datapath/PC width.
- NUM_BP, 4, number of breakpoint comparators (1..16).
- CTRL_W, 24, width of the packed control bundle. Bit 0 is reg_write; bit 1 is mem_to_reg (load).
- BPI_W, 2, breakpoint index width; must satisfy 2**BPI_W >= NUM_BP.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- if_id_instruction  in  32  instruction from IF/ID.
- if_id_pc_next  in  XLEN  PC+4 of that instruction.
- if_id_valid  in  1  IF/ID holds a real instruction.
- ctrl_in  in  CTRL_W  decoded control for if_id_instruction.
- flush_id  in  1  discard the instruction in ID (branch/jump redirect).
- bp_wr_en  in  1  write one breakpoint slot.
- bp_wr_idx  in  BPI_W  slot index.
- bp_wr_addr  in  XLEN  instruction address (PC, not PC+4).
- bp_wr_arm  in  1  armed bit written to the slot.
- continue_sig  in  1  level; resume from HALT.
- step_sig  in  1  level; issue exactly one instruction from HALT.
- id_ex_valid  out  1  EX holds a real instruction.
- id_ex_ctrl  out  CTRL_W  registered control bundle.
- id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt  out  5 each  register fields.
- id_ex_imm_sign_extended  out  XLEN  sign-extended imm[15:0].
- id_ex_pc_next  out  XLEN  registered PC+4.
- stall  out  1  load-use stall request to IF/PC (combinational).
- stall_breakpoint  out  1  debug halt request to IF/PC (combinational).
- bp_hit_idx  out  BPI_W  lowest-index slot that caused the last halt.
- dbg_state  out  2  00 RUN, 01 HALT, 10 STEP.

## Operation
Reset (rst=1 at a clock edge):
- All id_ex_* outputs go to 0 and id_ex_valid goes to 0.
- All breakpoint slots are cleared and disarmed.
- bp_hit_idx goes to 0, dbg_state goes to RUN, and skip goes to 0.

Breakpoint match:
- Signal match = if_id_valid & ~flush_id & ~skip & (some armed slot has addr == if_id_pc_next − 4).
- The address compare wraps modulo 2^XLEN.

Load-use stall:
- stall = id_ex_valid & id_ex_ctrl[1] & (id_ex_rt != 0) & (id_ex_rt == rs | id_ex_rt == rt).
- rs, rt and rd are instruction bits [25:21], [20:16] and [15:11].

ID/EX register update, first matching rule wins:
1. rst.
2. flush_id → bubble.
3. stall → bubble.
4. Debug block → bubble. Debug block = (RUN & match) | HALT | (STEP & ~if_id_valid).
5. Otherwise the register loads the decoded instruction, with id_ex_valid = if_id_valid.

A bubble sets every id_ex_* field to 0, including id_ex_valid.

Issue and stall_breakpoint:
- issue = the register loaded the instruction (rule 5) with if_id_valid = 1.
- stall_breakpoint = 1 whenever rule 4 would bubble, even if rules 2/3 fire first. The exception is flush_id, which forces stall_breakpoint to 0.

Debug FSM:
- RUN → HALT on match. bp_hit_idx captures the lowest matching slot.
- HALT → RUN when continue_sig = 1; skip is set to 1. If continue_sig and step_sig are both 1, continue wins.
- HALT → STEP when step_sig = 1 and continue_sig = 0; skip is set to 1.
- STEP → HALT on issue. While STEP waits for a valid, unstalled instruction, it stays in STEP.
- skip clears on the first issue after it was set. It also clears on flush_id.

Other rules:
- flush_id in HALT or STEP does not change the state.
- Breakpoint write: on bp_wr_en, slot[bp_wr_idx] ← {bp_wr_arm, bp_wr_addr}. The new value first affects match in the next cycle. An index ≥ NUM_BP is ignored.

## Timing
- stall and stall_breakpoint are combinational in the same cycle, computed from the current IF/ID inputs and current state.
- Decode-to-EX latency is one cycle.
- A load in EX with a dependent instruction in ID gives exactly one bubble.
- Halt entry: the matched instruction is held in IF/ID and no fetch advance occurs. The first bubble enters EX on the next edge.
- Resume: continue_sig sampled at edge N means the halted instruction issues at edge N+1 (unless stalled or flushed).
- Step: one instruction issues, then the FSM re-halts. The following instruction is held even if it has no breakpoint.
- Reset mid-halt returns the FSM to RUN and discards all breakpoints.

## Configuration
- ID_BREAKPOINT_EN defined: the slots, the FSM, skip and bp_hit_idx are built as above.
- ID_BREAKPOINT_EN undefined:
  - the breakpoint slots, FSM, skip and bp_hit_idx are not built;
  - stall_breakpoint, bp_hit_idx and dbg_state are tied to 0;
  - bp_wr_*, continue_sig and step_sig are ignored;
  - rule 4 never fires.

## Test plan
- Load-use: lw $t0 in EX, add using $t0 in ID → stall=1 for one cycle, one bubble; lw $zero-target → stall=0.
- Halt: arm slot 2 at 0x30; instruction at PC 0x30 reaches ID → stall_breakpoint=1, dbg_state=01, bp_hit_idx=2, id_ex_valid=0 until continue.
- Continue: in HALT assert continue_sig one cycle → instruction 0x30 issues next edge, not re-halted; a later pass through 0x30 halts again.
- Step: halted at 0x30, step_sig pulse → 0x30 issues, dbg_state returns to 01 holding 0x34; step_sig+continue_sig together → RUN.
- Flush: armed bp at 0x40 with flush_id=1 in the same cycle → no halt, stall_breakpoint=0, bubble in EX.
- Reset: rst during HALT → dbg_state=00, all slots disarmed, all id_ex_* = 0 next cycle.
